// File: rtl/rlwe_pipe_vrf_pkg.sv
// Shared defines for the pipelined scalar/vector register file.
// Default geometry plus the lane, vector and address types used around the core.
package rlwe_pipe_vrf_pkg;

    localparam int VRF_XLEN  = 32;
    localparam int VRF_LANES = 4;
    localparam int VRF_NREGS = 32;
    localparam int VRF_NRD   = 2;
    localparam int VRF_AW    = $clog2(VRF_NREGS);

    typedef logic [VRF_XLEN-1:0]        type_vrf_lane;
    typedef type_vrf_lane [VRF_LANES-1:0] type_vrf_vec;
    typedef logic [VRF_AW-1:0]          type_vrf_addr;

endpackage

// File: rtl/rlwe_pipe_vrf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register per file, a registered
// population count, and a sticky error for re-issue onto a busy register.
module rlwe_vrf_scoreboard #(
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sb_set,
    input  logic [AW-1:0]            sb_addr,
    input  logic                     sb_is_vector,
    input  logic                     clr_valid,
    input  logic [AW-1:0]            clr_addr,
    input  logic                     clr_is_vector,
    input  logic [NRD-1:0][AW-1:0]   rd_addr,
    input  logic [NRD-1:0]           rd_is_vector,
    output logic [NRD-1:0]           rd_busy,
    output logic [AW+1:0]            sb_count,
    output logic                     sb_err
);

    localparam logic [AW+1:0] CNT_ONE = {{(AW+1){1'b0}}, 1'b1};

    logic [1:0][NREGS-1:0] busy_q, busy_d;
    logic [AW+1:0]         cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic set_en, clr_en, same_reg, set_was_busy, clr_was_busy, inc, dec;

    assign set_en       = sb_set & (sb_addr != '0);
    assign clr_en       = clr_valid & (clr_addr != '0);
    assign same_reg     = (sb_addr == clr_addr) & (sb_is_vector == clr_is_vector);
    assign set_was_busy = busy_q[sb_is_vector][sb_addr];
    assign clr_was_busy = busy_q[clr_is_vector][clr_addr];

    // A set landing on the register being cleared re-arms it, so the clear
    // contributes nothing to the count in that case.
    assign inc = set_en & ~set_was_busy;
    assign dec = clr_en & clr_was_busy & ~(set_en & same_reg);

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        if (clr_en) busy_d[clr_is_vector][clr_addr] = 1'b0;
        if (set_en) busy_d[sb_is_vector][sb_addr] = 1'b1;
        if (inc & ~dec) cnt_d = cnt_q + CNT_ONE;
        else if (dec & ~inc) cnt_d = cnt_q - CNT_ONE;
        if (set_en & set_was_busy & ~(clr_en & same_reg)) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_busy[i] = rst_n & (rd_addr[i] != '0)
                       & busy_q[rd_is_vector[i]][rd_addr[i]]
                       & ~(clr_en & (clr_addr == rd_addr[i])
                                  & (clr_is_vector == rd_is_vector[i]));
        end
    end

    assign sb_count = cnt_q;
    assign sb_err   = err_q;

endmodule

// File: rtl/rlwe_pipe_vrf.sv
// Dual scalar/vector register file with NRD read ports, a masked pipeline
// write port, a valid/ready long-latency write port and write-to-read bypass.
module rlwe_pipe_vrf
    import rlwe_pipe_vrf_pkg::*;
#(
    parameter int XLEN  = VRF_XLEN,
    parameter int LANES = VRF_LANES,
    parameter int NREGS = VRF_NREGS,
    parameter int NRD   = VRF_NRD,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NRD-1:0][AW-1:0]              rd_addr,
    input  logic [NRD-1:0]                      rd_is_vector,
    output logic [NRD-1:0][LANES-1:0][XLEN-1:0] rd_data,
    output logic [NRD-1:0]                      rd_busy,
    input  logic                                wa_req,
    input  logic [AW-1:0]                       wa_addr,
    input  logic                                wa_is_vector,
    input  logic [LANES-1:0]                    wa_lane_mask,
    input  logic [LANES-1:0][XLEN-1:0]          wa_data,
    input  logic                                wb_valid,
    output logic                                wb_ready,
    input  logic [AW-1:0]                       wb_addr,
    input  logic                                wb_is_vector,
    input  logic [LANES-1:0][XLEN-1:0]          wb_data,
    input  logic                                sb_set,
    input  logic [AW-1:0]                       sb_addr,
    input  logic                                sb_is_vector,
    output logic [AW+1:0]                       sb_count,
    output logic                                sb_err
);

    typedef logic [LANES-1:0][XLEN-1:0] vec_t;

    logic [XLEN-1:0] sreg_q [NREGS];
    logic [XLEN-1:0] sreg_d [NREGS];
    vec_t            vreg_q [NREGS];
    vec_t            vreg_d [NREGS];

    logic wb_hs, wa_en, wb_en;

    // Pipeline port owns a contended register; the long-latency unit waits.
    assign wb_ready = ~(wa_req & (wa_addr == wb_addr)
                        & (wa_is_vector == wb_is_vector) & (wb_addr != '0));
    assign wb_hs    = wb_valid & wb_ready;
    assign wa_en    = wa_req & (wa_addr != '0);
    assign wb_en    = wb_hs & (wb_addr != '0);

    always_comb begin
        sreg_d = sreg_q;
        vreg_d = vreg_q;
        if (wa_en) begin
            if (wa_is_vector) begin
                for (int l = 0; l < LANES; l++) begin
                    if (wa_lane_mask[l]) vreg_d[wa_addr][l] = wa_data[l];
                end
            end else begin
                sreg_d[wa_addr] = wa_data[0];
            end
        end
        if (wb_en) begin
            if (wb_is_vector) vreg_d[wb_addr] = wb_data;
            else              sreg_d[wb_addr] = wb_data[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                sreg_q[r] <= '0;
                vreg_q[r] <= '0;
            end
        end else begin
            sreg_q <= sreg_d;
            vreg_q <= vreg_d;
        end
    end

    // Reading the next-state image gives the bypass for free: the two ports
    // never target the same register in one cycle, and x0 is never written.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            if (rst_n && (rd_addr[i] != '0)) begin
                if (rd_is_vector[i]) rd_data[i] = vreg_d[rd_addr[i]];
                else                 rd_data[i] = {LANES{sreg_d[rd_addr[i]]}};
            end
        end
    end

    rlwe_vrf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .sb_set        (sb_set),
        .sb_addr       (sb_addr),
        .sb_is_vector  (sb_is_vector),
        .clr_valid     (wb_hs),
        .clr_addr      (wb_addr),
        .clr_is_vector (wb_is_vector),
        .rd_addr       (rd_addr),
        .rd_is_vector  (rd_is_vector),
        .rd_busy       (rd_busy),
        .sb_count      (sb_count),
        .sb_err        (sb_err)
    );

endmodule

// File: tb/tb_rlwe_pipe_vrf.sv
// Scoreboard bench for rlwe_pipe_vrf: directed scenarios then random traffic,
// each cycle's expected outputs come from a behavioural register-file model.
module tb_rlwe_pipe_vrf;
    import rlwe_pipe_vrf_pkg::*;

    localparam int XLEN  = 32;
    localparam int LANES = 4;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    typedef logic [LANES-1:0][XLEN-1:0] vec_t;
    typedef struct packed {
        logic [NRD-1:0][LANES-1:0][XLEN-1:0] rd;
        logic [NRD-1:0]                      busy;
        logic                                rdy;
        logic [AW+1:0]                       cnt;
        logic                                err;
    } exp_t;

    logic                                clk;
    logic                                rst_n;
    logic [NRD-1:0][AW-1:0]              rd_addr;
    logic [NRD-1:0]                      rd_is_vector;
    logic [NRD-1:0][LANES-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]                      rd_busy;
    logic                                wa_req;
    logic [AW-1:0]                       wa_addr;
    logic                                wa_is_vector;
    logic [LANES-1:0]                    wa_lane_mask;
    vec_t                                wa_data;
    logic                                wb_valid;
    logic                                wb_ready;
    logic [AW-1:0]                       wb_addr;
    logic                                wb_is_vector;
    vec_t                                wb_data;
    logic                                sb_set;
    logic [AW-1:0]                       sb_addr;
    logic                                sb_is_vector;
    logic [AW+1:0]                       sb_count;
    logic                                sb_err;

    rlwe_pipe_vrf #(
        .XLEN(XLEN), .LANES(LANES), .NREGS(NREGS), .NRD(NRD), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_is_vector(rd_is_vector),
        .rd_data(rd_data), .rd_busy(rd_busy),
        .wa_req(wa_req), .wa_addr(wa_addr), .wa_is_vector(wa_is_vector),
        .wa_lane_mask(wa_lane_mask), .wa_data(wa_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
        .wb_is_vector(wb_is_vector), .wb_data(wb_data),
        .sb_set(sb_set), .sb_addr(sb_addr), .sb_is_vector(sb_is_vector),
        .sb_count(sb_count), .sb_err(sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    exp_t exp_q [$];

    // Reference state: plain arrays of register contents and pending flags.
    logic [XLEN-1:0] m_s [NREGS];
    vec_t            m_v [NREGS];
    bit              m_bz [2][NREGS];
    bit              m_err;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic vec_t bcast(input logic [XLEN-1:0] x);
        vec_t r;
        for (int l = 0; l < LANES; l++) r[l] = x;
        return r;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("rd_data",  256'(rd_data),  256'(e.rd));
            check("rd_busy",  256'(rd_busy),  256'(e.busy));
            check("wb_ready", 256'(wb_ready), 256'(e.rdy));
            check("sb_count", 256'(sb_count), 256'(e.cnt));
            check("sb_err",   256'(sb_err),   256'(e.err));
        end
    end

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_s[r] = '0;
            m_v[r] = '0;
            m_bz[0][r] = 1'b0;
            m_bz[1][r] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    // Predict this cycle's outputs, queue them, then advance the model past the edge.
    task automatic step();
        exp_t e;
        bit rdy, hs, clr_same;
        vec_t val;
        int pc;
        logic [AW-1:0] a;
        logic v;
        rdy = !(wa_req && wa_addr == wb_addr && wa_is_vector == wb_is_vector && wb_addr != 0);
        hs  = wb_valid && rdy;
        for (int i = 0; i < NRD; i++) begin
            a = rd_addr[i];
            v = rd_is_vector[i];
            if (!rst_n || a == 0) val = '0;
            else if (hs && wb_addr == a && wb_is_vector == v)
                val = v ? wb_data : bcast(wb_data[0]);
            else if (wa_req && wa_addr == a && wa_is_vector == v) begin
                if (v) begin
                    for (int l = 0; l < LANES; l++)
                        val[l] = wa_lane_mask[l] ? wa_data[l] : m_v[a][l];
                end else val = bcast(wa_data[0]);
            end else val = v ? m_v[a] : bcast(m_s[a]);
            e.rd[i]   = val;
            e.busy[i] = rst_n && a != 0 && m_bz[v][a]
                        && !(hs && wb_addr == a && wb_is_vector == v);
        end
        pc = 0;
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < NREGS; r++) pc += int'(m_bz[f][r]);
        e.rdy = rdy;
        e.cnt = rst_n ? (AW+2)'(pc) : '0;
        e.err = rst_n ? m_err : 1'b0;
        exp_q.push_back(e);

        if (!rst_n) model_reset();
        else begin
            if (wa_req && wa_addr != 0) begin
                if (wa_is_vector) begin
                    for (int l = 0; l < LANES; l++)
                        if (wa_lane_mask[l]) m_v[wa_addr][l] = wa_data[l];
                end else m_s[wa_addr] = wa_data[0];
            end
            if (hs && wb_addr != 0) begin
                if (wb_is_vector) m_v[wb_addr] = wb_data;
                else              m_s[wb_addr] = wb_data[0];
            end
            clr_same = hs && wb_addr == sb_addr && wb_is_vector == sb_is_vector;
            if (sb_set && sb_addr != 0 && m_bz[sb_is_vector][sb_addr] && !clr_same)
                m_err = 1'b1;
            if (hs && wb_addr != 0) m_bz[wb_is_vector][wb_addr] = 1'b0;
            if (sb_set && sb_addr != 0) m_bz[sb_is_vector][sb_addr] = 1'b1;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        rd_addr = '0; rd_is_vector = '0;
        wa_req = 0; wa_addr = '0; wa_is_vector = 0; wa_lane_mask = '0; wa_data = '0;
        wb_valid = 0; wb_addr = '0; wb_is_vector = 0; wb_data = '0;
        sb_set = 0; sb_addr = '0; sb_is_vector = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input int p, input int a, input bit v);
        rd_addr[p] = AW'(a);
        rd_is_vector[p] = v;
    endtask

    task automatic wa(input int a, input bit v, input logic [LANES-1:0] m, input vec_t d);
        wa_req = 1; wa_addr = AW'(a); wa_is_vector = v; wa_lane_mask = m; wa_data = d;
    endtask

    task automatic wb(input int a, input bit v, input vec_t d);
        wb_valid = 1; wb_addr = AW'(a); wb_is_vector = v; wb_data = d;
    endtask

    task automatic sb(input int a, input bit v);
        sb_set = 1; sb_addr = AW'(a); sb_is_vector = v;
    endtask

    initial begin
        vec_t pat_p, pat_a, pat_b, tmp;
        idle();
        model_reset();
        rst_n = 0;
        tick(); rst_n = 0; rd(0, 5, 0); rd(1, 5, 1); wa(5, 1, 4'hF, bcast(32'hDEAD)); step();
        tick(); rst_n = 1; rd(0, 5, 0); rd(1, 5, 1); step();

        tick(); wa(3, 1, 4'hF, bcast(32'hA5)); rd(0, 3, 1); rd(1, 0, 0); step();
        tick(); wa(0, 0, 4'hF, bcast(32'hFF)); rd(0, 0, 0); rd(1, 3, 1); step();
        tick(); rd(0, 3, 1); rd(1, 0, 1); step();

        tick(); wa(4, 1, 4'hF, {32'd8, 32'd7, 32'd6, 32'd5}); step();
        tick(); wa(4, 1, 4'b0101, {32'd4, 32'd3, 32'd2, 32'd1}); rd(0, 4, 1); step();
        check("merge_bypass", 256'(rd_data[0]), 256'({32'd8, 32'd3, 32'd6, 32'd1}));
        tick(); rd(0, 4, 1); step();
        check("merge_stored", 256'(rd_data[0]), 256'({32'd8, 32'd3, 32'd6, 32'd1}));

        tick(); wa(7, 0, 4'b0001, {32'd9, 32'd9, 32'd9, 32'h1234}); rd(1, 7, 0); step();
        tick(); rd(0, 7, 0); rd(1, 7, 1); step();
        check("scalar_bcast", 256'(rd_data[0]), 256'(bcast(32'h1234)));

        pat_p = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
        tick(); sb(9, 1); rd(0, 9, 1); step();
        tick(); rd(0, 9, 1); step();
        check("busy_after_set", 256'(rd_busy[0]), 256'(1));
        check("count_after_set", 256'(sb_count), 256'(1));
        tick(); wb(9, 1, pat_p); rd(0, 9, 1); step();
        check("wb_bypass_busy", 256'(rd_busy[0]), 256'(0));
        tick(); rd(0, 9, 1); step();
        check("count_after_clr", 256'(sb_count), 256'(0));

        pat_a = bcast(32'h1111_2222);
        pat_b = bcast(32'h3333_4444);
        tick(); wa(2, 1, 4'hF, pat_a); wb(2, 1, pat_b); rd(0, 2, 1); step();
        check("collide_stall", 256'(wb_ready), 256'(0));
        tick(); wb(2, 1, pat_b); rd(0, 2, 1); step();
        tick(); rd(0, 2, 1); step();
        check("collide_final", 256'(rd_data[0]), 256'(pat_b));

        tick(); sb(1, 1); step();
        tick(); sb(1, 1); step();
        tick(); rd(0, 1, 1); step();
        check("err_sticky", 256'(sb_err), 256'(1));
        check("count_dup_set", 256'(sb_count), 256'(1));
        tick(); sb(6, 1); step();
        tick(); sb(6, 1); wb(6, 1, pat_a); rd(0, 6, 1); step();
        tick(); rd(0, 6, 1); step();
        check("set_clr_same", 256'(rd_busy[0]), 256'(1));
        check("count_set_clr", 256'(sb_count), 256'(2));

        tick(); sb(11, 1); step();
        tick(); rst_n = 0; rd(0, 11, 1); step();
        tick(); rst_n = 1; wb(11, 1, pat_p); rd(0, 11, 1); step();
        tick(); rd(0, 11, 1); rd(1, 6, 1); step();

        for (int c = 0; c < 600; c++) begin
            tick();
            rst_n = ($urandom_range(0, 149) != 0);
            for (int i = 0; i < NRD; i++) rd(i, $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) < 4) begin
                for (int l = 0; l < LANES; l++) tmp[l] = $urandom();
                wa($urandom_range(0, 7), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), tmp);
            end
            if ($urandom_range(0, 9) < 4) begin
                for (int l = 0; l < LANES; l++) tmp[l] = $urandom();
                wb($urandom_range(0, 7), 1'($urandom_range(0, 1)), tmp);
            end
            if ($urandom_range(0, 9) < 3) sb($urandom_range(0, 7), 1'($urandom_range(0, 1)));
            step();
        end

        tick();
        rst_n = 1;
        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rlwe_pipe_vrf.md
Name: rlwe_pipe_vrf

Overview:
Parametrised successor of the RLWE core's dual scalar/vector register file. Holds NREGS scalar and NREGS vector (LANES x XLEN) registers. Adds NRD read ports, a per-lane masked pipeline write port, and a second valid/ready write port for long-latency units (NTT/polymul). A pending-write scoreboard tells the EXU when a source register is not yet valid; same-cycle write-to-read bypass is included.

Parameters:
XLEN, 32, scalar/lane width in bits
LANES, 4, vector lanes (matches `LANE)
NREGS, 32, registers per file incl. hard-wired x0 (16 for RVE builds)
NRD, 2, number of read ports
AW, $clog2(NREGS), register address width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
rd_addr  in  NRD x AW  read addresses
rd_is_vector  in  NRD  1 = read vector file, 0 = scalar file
rd_data  out  NRD x LANES x XLEN  read data; scalar reads are broadcast to all lanes
rd_busy  out  NRD  source register has a pending long-latency write
wa_req  in  1  pipeline write request
wa_addr  in  AW  pipeline write address
wa_is_vector  in  1  pipeline write target file
wa_lane_mask  in  LANES  per-lane enable (vector only)
wa_data  in  LANES x XLEN  pipeline write data
wb_valid  in  1  long-latency write valid
wb_ready  out  1  long-latency write accepted
wb_addr  in  AW  long-latency write address
wb_is_vector  in  1  long-latency write target file
wb_data  in  LANES x XLEN  long-latency write data
sb_set  in  1  mark a register pending (long-latency op issued)
sb_addr  in  AW  register to mark
sb_is_vector  in  1  file of the marked register
sb_count  out  AW+2  number of pending registers (both files)
sb_err  out  1  sticky: sb_set hit an already-busy register

Behaviour:
- Reset (async, rst_n=0): all registers 0, all busy bits 0, sb_count=0, sb_err=0. rd_data reads 0 and rd_busy is 0 while reset is held. Reset during an outstanding op drops it; a later wb handshake to that register still writes.
- Address 0 in either file reads all-zero and is never busy. Writes and sb_set to address 0 are ignored.
- Read is combinational. Priority: addr 0 -> zero; else same-cycle accepted wb write to that register -> wb data; else same-cycle wa write -> merge of masked wa lanes with stored lanes; else stored value. Scalar read = {LANES{scalar}}.
- Scalar writes take lane 0 only and ignore wa_lane_mask. Vector wa writes update only the lanes whose mask bit is 1. wb writes always write all lanes.
- wb_ready = ~(wa_req & wa_addr==wb_addr & wa_is_vector==wb_is_vector & wb_addr!=0). On a same-register collision, wa wins and wb stalls one cycle or more. The handshake is wb_valid & wb_ready; the write commits at that posedge. Writes to distinct registers from both ports commit in the same cycle.
- Scoreboard: one busy bit per register per file. Set by sb_set; cleared by a wb handshake to that register. Set and clear of the same register in the same cycle: the register stays busy (a new op has been issued).
- sb_set to a register that is already busy and not clearing that cycle: the busy bit stays 1, sb_count is unchanged, and sb_err is set and holds until reset.
- rd_busy[i] = busy[file][addr] & ~(wb handshake to the same register this cycle).
- sb_count is registered and equals the population of busy bits, updated by +1, -1 or 0 per cycle. It never wraps, because the maximum is 2*(NREGS-1).
- wb handshake to a non-busy register: the write still happens and the count is unchanged (not an error).
- wa writes do not touch the scoreboard.

Decomposition:
- Add to the shared defines package: type_vrf_lane (XLEN), type_vrf_vec (LANES x lane), type_vrf_addr.
- One natural sub-module, rlwe_vrf_scoreboard: busy bits, set/clear resolution, sb_count, sb_err, rd_busy.
- The storage, write ports and bypass stay in the top level.

Test Plan:
- Reset, then read x5 scalar and v5 vector -> rd_data=0, rd_busy=0, sb_count=0. Write wa v3 with all lanes 0xA5 and x0; read both -> v3 all lanes 0xA5, x0 reads 0.
- wa vector write v4, mask 4'b0101, data lanes {4,3,2,1}, over stored {8,7,6,5} -> same-cycle read returns {8,3,6,1}; the next cycle shows the same value from storage.
- Scalar wa write x7=0x1234 with data lanes {9,9,9,0x1234} -> read x7 gives 0x1234 on all lanes.
- sb_set v9 -> rd_busy=1 and sb_count=1 next cycle. wb_valid v9 = pattern P -> wb_ready=1, same-cycle read returns P with rd_busy=0, sb_count=0 next cycle.
- wa_req and wb_valid both to v2 -> wb_ready=0 and v2 takes wa data. Drop wa next cycle -> wb handshake completes and v2 = wb data.
- sb_set v1 twice without a clear -> sb_err=1 (sticky), sb_count=1. In one cycle, sb_set v6 together with a wb handshake to v6 (v6 already busy) -> v6 stays busy, sb_count unchanged.
